// File: rtl/counter_cmd_ctrl.sv
// rtl/counter_cmd_ctrl.sv - multi-channel counter control from buttons and UART command bytes
module counter_cmd_ctrl #(
  parameter int NUM_CH  = 2,
  parameter int MODE_W  = 2,
  parameter int HOLDOFF = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          i_enable,
  input  logic [NUM_CH-1:0]          i_clear,
  input  logic [NUM_CH-1:0]          i_mode,
  input  logic [7:0]                 i_rx_data,
  input  logic                       i_rx_valid,
  output logic                       o_rx_ready,
  output logic [NUM_CH-1:0]          o_enable,
  output logic [NUM_CH-1:0]          o_clear,
  output logic [NUM_CH*MODE_W-1:0]   o_mode,
  output logic [3:0]                 o_sel_ch,
  output logic                       o_busy
);

  // Hold counter runs 0..HOLDOFF-1 while in HOLD.
  localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [NUM_CH-1:0]          en_q, en_d;
  logic [NUM_CH-1:0]          clr_q, clr_d;
  logic [NUM_CH*MODE_W-1:0]   mode_q, mode_d;
  logic [3:0]                 sel_q, sel_d;

  logic [NUM_CH-1:0]          btn_any;
  logic                       btn_fire;
  logic                       is_digit;
  logic                       go_hold;
  logic                       found;

  assign btn_any  = i_enable | i_clear | i_mode;
  assign btn_fire = |btn_any;
  assign is_digit = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39);

  // Buttons take precedence, so the FIFO is only popped in an idle cycle with no button request.
  assign o_rx_ready = (state_q == IDLE) && !btn_fire;
  assign o_busy     = (state_q == HOLD);
  assign o_enable   = en_q;
  assign o_clear    = clr_q;
  assign o_mode     = mode_q;
  assign o_sel_ch   = sel_q;

  // Next-state and command decode; clear pulses default low so they last a single cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    clr_d   = '0;
    mode_d  = mode_q;
    sel_d   = sel_q;
    go_hold = 1'b0;
    found   = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_fire) begin
          go_hold = 1'b1;
          // Lowest requesting channel wins; enable beats clear beats mode.
          for (int k = 0; k < NUM_CH; k++) begin
            if (!found && btn_any[k]) begin
              found = 1'b1;
              if (i_enable[k])
                en_d[k] = ~en_q[k];
              else if (i_clear[k])
                clr_d[k] = 1'b1;
              else
                mode_d[k*MODE_W +: MODE_W] = mode_q[k*MODE_W +: MODE_W] + MODE_W'(1);
            end
          end
        end else if (i_rx_valid) begin
          if (is_digit) begin
            if (int'(i_rx_data[3:0]) < NUM_CH)
              sel_d = i_rx_data[3:0];
          end else begin
            case (i_rx_data)
              8'h72: begin
                go_hold = 1'b1;
                for (int k = 0; k < NUM_CH; k++)
                  if (4'(k) == sel_q) en_d[k] = ~en_q[k];
              end
              8'h63: begin
                go_hold = 1'b1;
                for (int k = 0; k < NUM_CH; k++)
                  if (4'(k) == sel_q) clr_d[k] = 1'b1;
              end
              8'h6D: begin
                go_hold = 1'b1;
                for (int k = 0; k < NUM_CH; k++)
                  if (4'(k) == sel_q)
                    mode_d[k*MODE_W +: MODE_W] = mode_q[k*MODE_W +: MODE_W] + MODE_W'(1);
              end
              8'h52: begin
                go_hold = 1'b1;
                en_d    = ~en_q;
              end
              8'h43: begin
                go_hold = 1'b1;
                clr_d   = '1;
              end
              default: ;
            endcase
          end
        end
        if (go_hold) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(HOLDOFF - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset re-enables every channel and aborts any holdoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= '1;
      clr_q   <= '0;
      mode_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: doc/counter_cmd_ctrl.md
Name: counter_cmd_ctrl

Overview:
Multi-channel successor of the single-channel counter control unit. It accepts per-channel button pulses and ASCII command bytes from the UART RX FIFO. For each of NUM_CH counter channels it drives a registered run-enable, a one-cycle clear pulse and a multi-bit mode. It sits between the button debouncers / UART-FIFO loopback path and the counter datapaths.

Parameters:
NUM_CH, 2, number of counter channels (1..10)
MODE_W, 2, width of each channel's mode field; mode wraps modulo 2^MODE_W
HOLDOFF, 2, cycles spent in HOLD after an executed command (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous and active-high
i_enable  in  NUM_CH  per-channel run-toggle request pulses
i_clear  in  NUM_CH  per-channel clear request pulses
i_mode  in  NUM_CH  per-channel mode-advance request pulses
i_rx_data  in  8  command byte from RX FIFO
i_rx_valid  in  1  RX FIFO not empty / byte valid
o_rx_ready  out  1  byte consumed this cycle when high with i_rx_valid (FIFO pop)
o_enable  out  NUM_CH  per-channel run enable
o_clear  out  NUM_CH  per-channel clear, one-cycle pulse
o_mode  out  NUM_CH*MODE_W  per-channel mode, channel k at [k*MODE_W +: MODE_W]
o_sel_ch  out  4  currently selected channel for UART commands
o_busy  out  1  high while in HOLD

Behaviour:
- All outputs are registered. On a clk edge with rst=1:
  - state=IDLE, o_enable all ones, o_clear=0, o_mode=0, o_sel_ch=0, hold counter=0.
  - Reset mid-HOLD aborts the holdoff immediately.
- FSM states: IDLE, HOLD.
- IDLE, button path (highest priority):
  - Fires if any bit of i_enable|i_clear|i_mode is set.
  - Acts on the lowest channel index k with any bit set. Other channels' requests that cycle are dropped.
  - Within channel k the priority is enable > clear > mode:
    - enable: o_enable[k] toggles.
    - clear: o_clear[k]=1 for the next cycle only.
    - mode: mode[k] = mode[k]+1, wrapping.
  - Go to HOLD. o_rx_ready=0 this cycle.
- IDLE, UART path:
  - o_rx_ready=1 only in IDLE when no button bit is set. The byte is accepted on i_rx_valid && o_rx_ready.
  - Byte decode:
    - '0'..'9' (0x30..0x39): value d. If d < NUM_CH then o_sel_ch=d, else ignored. Stay IDLE.
    - 'r' (0x72): toggle o_enable[sel]. Go to HOLD.
    - 'c' (0x63): clear pulse on sel. Go to HOLD.
    - 'm' (0x6D): advance mode[sel]. Go to HOLD.
    - 'R' (0x52): toggle all o_enable bits. Go to HOLD.
    - 'C' (0x43): clear pulse on all channels. Go to HOLD.
    - Any other byte: consumed and dropped. Stay IDLE.
- HOLD:
  - Lasts exactly HOLDOFF cycles, then returns to IDLE.
  - o_busy=1, o_rx_ready=0. Button pulses arriving during HOLD are discarded, not queued.
  - UART bytes remain in the FIFO.
- Timing:
  - Effects appear on outputs the cycle after acceptance (1-cycle latency).
  - o_clear is never high for two consecutive cycles from one command.
- Selection:
  - o_sel_ch is unaffected by button commands.
  - Out-of-range digits leave o_sel_ch unchanged.

Test Plan:
- Reset → o_enable=2'b11, o_mode=0, o_clear=0, o_sel_ch=0, o_rx_ready=1 with rx valid.
- i_enable=2'b10 for one cycle → o_enable=2'b01 next cycle, o_busy high for 2 cycles; a second i_enable=2'b10 pulse during HOLD is ignored, o_enable stays 2'b01.
- Same cycle i_enable[0]=1, i_clear[0]=1, i_mode[1]=1 → only o_enable[0] toggles; no clear, mode[1] stays 0.
- Bytes '1','m','m','m','m' streamed back-to-back, valid held → o_sel_ch=1; mode[1] goes 1,2,3,0; each 'm' is accepted 3 cycles after the previous (1 accept + 2 HOLD).
- Bytes '7' (NUM_CH=2), 'x', then 'C' → o_sel_ch stays 0; 'x' popped with no effect; o_clear=2'b11 for exactly one cycle.
- Assert rst during HOLD after 'R' → next cycle state IDLE, o_busy=0, o_enable=2'b11, o_rx_ready=1.
